// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap/return sequencer of the 3-stage pipeline.
//   trap_state_e        : sequencer FSM states (RUN accepts interrupts, COOL masks them)
//   CAUSE_M_EXT_INT     : mcause exception code for a machine external interrupt
//   MTVEC_MODE_VECTORED : mtvec[1:0] encoding for vectored interrupt dispatch
//   vector_offset()     : byte offset added to the mtvec base in vectored mode
package trap_sequencer_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    COOL = 1'b1
  } trap_state_e;

  localparam int unsigned    CAUSE_M_EXT_INT     = 11;
  localparam logic [1:0]     MTVEC_MODE_VECTORED = 2'b01;

  // Vectored dispatch lands on base + 4*cause.
  function automatic int unsigned vector_offset(input int unsigned cause);
    return cause * 4;
  endfunction

endpackage

// File: rtl/trap_sequencer_sync_ff.sv
// Multi-flop bit synchroniser for asynchronous level inputs.
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears every stage
//   din  : asynchronous input bit
//   dout : input as seen SYNC_STAGES clock edges later
module trap_sequencer_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// Interrupt-entry / mret-return sequencer for the F / E / M-W pipeline.
// Synchronises ext_int, arbitrates it against mret, and produces the fetch
// redirect, flush/squash strobes and CSR trap/return pulses.
//   clk, rst                     : clock, synchronous active-high reset
//   ext_int                      : asynchronous level external interrupt
//   mstatus_mie, mie_meie        : interrupt enables from the CSR file
//   mtvec, mepc                  : trap vector and return address CSRs
//   pc_f, pc_e, valid_e          : fetch/execute PCs and execute-valid
//   br_taken                     : branch resolved taken in execute
//   is_mret_m                    : mret in the M-W stage
//   trap_take/trap_epc/trap_cause: CSR trap-entry pulse and write data
//   ret_take                     : CSR mret pulse
//   redirect/redirect_pc         : fetch PC override
//   flush_d, squash_e            : F->E zero, E->M control zero
//   int_pending                  : synchronised ext_int
//   trap_count                   : saturating count of traps taken
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int COOL_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_int,
  input  logic             mstatus_mie,
  input  logic             mie_meie,
  input  logic [WIDTH-1:0] mtvec,
  input  logic [WIDTH-1:0] mepc,
  input  logic [WIDTH-1:0] pc_f,
  input  logic [WIDTH-1:0] pc_e,
  input  logic             valid_e,
  input  logic             br_taken,
  input  logic             is_mret_m,
  output logic             trap_take,
  output logic [WIDTH-1:0] trap_epc,
  output logic [WIDTH-1:0] trap_cause,
  output logic             ret_take,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_d,
  output logic             squash_e,
  output logic             int_pending,
  output logic [CNT_W-1:0] trap_count
);

  localparam int              CW        = $clog2(COOL_CYCLES + 1);
  localparam logic [CW-1:0]   COOL_LOAD = CW'(COOL_CYCLES);
  localparam logic [WIDTH-1:0] CAUSE_VAL =
    {1'b1, {(WIDTH-5){1'b0}}, 4'(CAUSE_M_EXT_INT)};
  localparam logic [WIDTH-1:0] VEC_OFF  = WIDTH'(vector_offset(CAUSE_M_EXT_INT));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  trap_state_e   state, state_nxt;
  logic [CW-1:0] cool_cnt, cool_cnt_nxt;
  logic          int_req;
  logic          ret_evt;
  logic          trap_evt;
  logic          kill_branch;
  logic [WIDTH-1:0] vec_base;

  trap_sequencer_sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (ext_int),
    .dout(int_pending)
  );

  assign int_req  = int_pending & mstatus_mie & mie_meie & (state == RUN);
  // Events are suppressed while rst is held so nothing leaks into the CSRs.
  assign ret_evt  = is_mret_m & ~rst;
  assign trap_evt = int_req & ~is_mret_m & ~rst;
  // A taken branch in E always belongs to a live instruction; the trap
  // records its PC so the branch re-executes after mret.
  assign kill_branch = trap_evt & br_taken;
  assign vec_base    = {mtvec[WIDTH-1:2], 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cool_cnt   <= '0;
      trap_count <= '0;
    end else begin
      state    <= state_nxt;
      cool_cnt <= cool_cnt_nxt;
      if (trap_evt) begin
        trap_count <= sat_inc(trap_count);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    cool_cnt_nxt = cool_cnt;
    if (ret_evt || trap_evt) begin
      state_nxt    = COOL;
      cool_cnt_nxt = COOL_LOAD;
    end else if (state == COOL) begin
      cool_cnt_nxt = cool_cnt - 1'b1;
      if (cool_cnt <= CW'(1)) begin
        state_nxt = RUN;
      end
    end
  end

  // Output logic
  always_comb begin
    trap_take   = 1'b0;
    ret_take    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    flush_d     = 1'b0;
    squash_e    = 1'b0;
    trap_epc    = '0;
    trap_cause  = '0;
    if (ret_evt) begin
      ret_take    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = mepc;
      flush_d     = 1'b1;
      squash_e    = 1'b1;
    end else if (trap_evt) begin
      trap_take   = 1'b1;
      redirect    = 1'b1;
      flush_d     = 1'b1;
      squash_e    = 1'b1;
      trap_epc    = (valid_e || kill_branch) ? pc_e : pc_f;
      trap_cause  = CAUSE_VAL;
      redirect_pc = (mtvec[1:0] == MTVEC_MODE_VECTORED) ? vec_base + VEC_OFF : vec_base;
    end
  end

endmodule
